// File: rtl/vga_timing_pipe.sv
// VGA raster timing generator with a pixel-request interface and a fixed-latency
// return pipeline; sync/blank are delayed to line up with the returned colour.
module vga_timing_pipe #(
  parameter int H_DISP    = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_DISP    = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter bit HS_ACTIVE = 1'b1,
  parameter bit VS_ACTIVE = 1'b1,
  parameter int COLOR_W   = 8,
  parameter int LATENCY   = 2,
  localparam int XW = $clog2(H_DISP),
  localparam int YW = $clog2(V_DISP)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic [1:0]             i_mode,
  input  logic [3*COLOR_W-1:0]   i_pix_rgb,
  output logic                   o_req,
  output logic [XW-1:0]          o_req_x,
  output logic [YW-1:0]          o_req_y,
  output logic [COLOR_W-1:0]     o_vga_r,
  output logic [COLOR_W-1:0]     o_vga_g,
  output logic [COLOR_W-1:0]     o_vga_b,
  output logic                   o_vga_hs,
  output logic                   o_vga_vs,
  output logic                   o_vga_blank,
  output logic                   o_vga_sync,
  output logic                   o_frame_start
);
  localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam int BAR_W   = H_DISP / 8;
  localparam int CW3     = 3 * COLOR_W;
  localparam int PW      = 5 + CW3;

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT  = HCW'(H_DISP);
  localparam logic [HCW-1:0] H_SS   = HCW'(H_DISP + H_FRONT);
  localparam logic [HCW-1:0] H_SE   = HCW'(H_DISP + H_FRONT + H_SYNC);
  localparam logic [HCW-1:0] B_LAST = HCW'(BAR_W - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT  = VCW'(V_DISP);
  localparam logic [VCW-1:0] V_SS   = VCW'(V_DISP + V_FRONT);
  localparam logic [VCW-1:0] V_SE   = VCW'(V_DISP + V_FRONT + V_SYNC);

  logic [HCW-1:0] r_hcnt;
  logic [VCW-1:0] r_vcnt;
  logic [1:0]     r_mode_q;
  logic [HCW-1:0] r_bar_cnt;
  logic [2:0]     r_bar_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_mode_q <= '0;
    end else if (i_en) begin
      if (r_hcnt == H_LAST) begin
        r_hcnt <= '0;
        if (r_vcnt == V_LAST) begin
          r_vcnt   <= '0;
          r_mode_q <= i_mode;
        end else begin
          r_vcnt <= r_vcnt + 1'b1;
        end
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  // Bar index follows hcnt without a divider; the last bar simply keeps running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (i_en) begin
      if (r_hcnt == H_LAST) begin
        r_bar_cnt <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_idx != 3'd7) begin
        if (r_bar_cnt == B_LAST) begin
          r_bar_cnt <= '0;
          r_bar_idx <= r_bar_idx + 1'b1;
        end else begin
          r_bar_cnt <= r_bar_cnt + 1'b1;
        end
      end
    end
  end

  logic                  w_act, w_hs, w_vs, w_fs;
  logic [HCW+COLOR_W+5:0] w_hext;
  logic [VCW+COLOR_W+5:0] w_vext;
  logic [CW3-1:0]        w_pat;
  logic [PW-1:0]         w_s0;

  assign w_act  = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs   = (r_hcnt >= H_SS) && (r_hcnt < H_SE);
  assign w_vs   = (r_vcnt >= V_SS) && (r_vcnt < V_SE);
  assign w_fs   = (r_hcnt == '0) && (r_vcnt == '0);
  assign w_hext = {{(COLOR_W+6){1'b0}}, r_hcnt};
  assign w_vext = {{(COLOR_W+6){1'b0}}, r_vcnt};

  // Bar colours white..black map to r=~idx[1], g=~idx[2], b=~idx[0].
  always_comb begin
    w_pat = '0;
    case (r_mode_q)
      2'd1:    w_pat = {{COLOR_W{~r_bar_idx[1]}}, {COLOR_W{~r_bar_idx[2]}},
                        {COLOR_W{~r_bar_idx[0]}}};
      2'd2:    w_pat = {CW3{w_hext[5] ^ w_vext[5]}};
      2'd3:    w_pat = {3{w_hext[COLOR_W-1:0]}};
      default: w_pat = '0;
    endcase
  end

  assign w_s0    = {w_act, w_hs, w_vs, w_fs, (r_mode_q == 2'd0), w_pat};
  assign o_req   = w_act;
  assign o_req_x = w_act ? r_hcnt[XW-1:0] : '0;
  assign o_req_y = w_act ? r_vcnt[YW-1:0] : '0;

  // Sync levels travel as "asserted" flags so a cleared stage means inactive.
  logic [PW-1:0] r_dly [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_dly[i] <= '0;
    end else if (i_en) begin
      r_dly[0] <= w_s0;
      for (int i = 1; i < LATENCY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  logic [PW-1:0] w_al;
  assign w_al = r_dly[LATENCY-1];

  logic           r_blank, r_hs, r_vs, r_fs;
  logic [CW3-1:0] r_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_fs    <= 1'b0;
      r_rgb   <= '0;
    end else if (i_en) begin
      r_blank <= w_al[PW-1];
      r_hs    <= w_al[PW-2];
      r_vs    <= w_al[PW-3];
      r_fs    <= w_al[PW-4];
      r_rgb   <= !w_al[PW-1] ? '0 : (w_al[PW-5] ? i_pix_rgb : w_al[CW3-1:0]);
    end
  end

  assign o_vga_r       = r_rgb[CW3-1 -: COLOR_W];
  assign o_vga_g       = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign o_vga_b       = r_rgb[COLOR_W-1:0];
  assign o_vga_hs      = r_hs ? HS_ACTIVE : ~HS_ACTIVE;
  assign o_vga_vs      = r_vs ? VS_ACTIVE : ~VS_ACTIVE;
  assign o_vga_blank   = r_blank;
  assign o_vga_sync    = 1'b0;
  assign o_frame_start = r_fs;
endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench for vga_timing_pipe on a reduced 96x40 raster (80x36 visible),
// with an upstream model returning {x, y, 8'h5A} two enabled cycles after req.
module tb_vga_timing_pipe;
  localparam int HD = 80, HF = 4, HSY = 8, HB = 4;
  localparam int VD = 36, VF = 1, VSY = 2, VB = 1;
  localparam int LAT = 2;
  localparam int HT = HD + HF + HSY + HB;
  localparam int VT = VD + VF + VSY + VB;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en = 1'b1;
  logic [1:0] mode;
  logic [23:0] pix;
  logic       req;
  logic [6:0] rx;
  logic [5:0] ry;
  logic [7:0] r, g, b;
  logic       hs, vs, blank, sync, fs;

  always #5 clk = ~clk;

  vga_timing_pipe #(
    .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .HS_ACTIVE(1'b1), .VS_ACTIVE(1'b1), .COLOR_W(8), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_mode(mode), .i_pix_rgb(pix),
    .o_req(req), .o_req_x(rx), .o_req_y(ry),
    .o_vga_r(r), .o_vga_g(g), .o_vga_b(b),
    .o_vga_hs(hs), .o_vga_vs(vs), .o_vga_blank(blank), .o_vga_sync(sync),
    .o_frame_start(fs)
  );

  // Upstream pixel source with a two-enabled-cycle return latency.
  logic [23:0] q1 = '0, q2 = '0;
  always @(posedge clk) if (en) begin
    q1 <= {1'b0, rx, 2'b00, ry, 8'h5A};
    q2 <= q1;
  end
  assign pix = q2;

  // Enabled edges since reset release; output pixel index = ocnt - (LAT+1).
  int ocnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ocnt <= 0;
    else if (en) ocnt <= ocnt + 1;

  bit          tog = 1'b0;
  logic [41:0] snap;
  int          stab_bad = 0;
  always @(negedge clk) begin
    if (tog && !en && ({r, g, b, hs, vs, blank, fs, req, rx, ry} !== snap))
      stab_bad <= stab_bad + 1;
    snap <= {r, g, b, hs, vs, blank, fs, req, rx, ry};
    en   <= tog ? ~en : 1'b1;
  end

  int total = 0, bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    int f, x, y, set_mode;
    logic [7:0] r, g, b;
    logic bl, hs, vs, fs;
  } vec_t;
  vec_t tv[$];

  function automatic void add(int f, int x, int y, int sm, logic [7:0] er, logic [7:0] eg,
                              logic [7:0] eb, logic ebl, logic ehs, logic evs, logic efs);
    vec_t v;
    v.f = f; v.x = x; v.y = y; v.set_mode = sm;
    v.r = er; v.g = eg; v.b = eb; v.bl = ebl; v.hs = ehs; v.vs = evs; v.fs = efs;
    tv.push_back(v);
  endfunction

  task automatic wait_n(int t);
    int gd = 0;
    while ((ocnt - LAT - 1) < t && gd < 8000) begin
      @(negedge clk);
      gd++;
    end
    if ((ocnt - LAT - 1) != t) begin
      total++; bad++;
      $display("FAIL wait target=%0d reached=%0d", t, ocnt - LAT - 1);
    end
  endtask

  function automatic logic sig(int w);
    case (w)
      0: return hs;
      1: return blank;
      2: return vs;
      default: return fs;
    endcase
  endfunction

  // Samples on negedges: hi = samples high after a rise, per = rise-to-rise distance.
  task automatic measure(int w, output int hi, output int per);
    logic p;
    int gd = 0;
    hi = 0;
    do begin
      p = sig(w);
      @(negedge clk);
      gd++;
    end while (!(!p && sig(w)) && gd < 20000);
    while (sig(w) && hi < 20000) begin hi++; @(negedge clk); end
    per = hi;
    while (!sig(w) && per < 40000) begin per++; @(negedge clk); end
  endtask

  task automatic release_check(string tag);
    rst_n = 1'b1;
    @(negedge clk); chk({tag, "_blank1"}, blank, 1'b0);
    @(negedge clk); chk({tag, "_blank2"}, blank, 1'b0);
    @(negedge clk); chk({tag, "_blank3"}, blank, 1'b1);
    chk({tag, "_fs3"}, fs, 1'b1);
    chk({tag, "_pix00"}, {r, g, b}, 24'h00005A);
  endtask

  initial begin
    int n, s, sx, sy, hi, per, gd;
    logic a;
    string nm;
    mode  = 2'd0;
    rst_n = 1'b0;

    // frame 0 external, mode->2 mid-frame
    add(0,  0,  0, -1, 8'h00, 8'h00, 8'h5A, 1, 0, 0, 1);
    add(0,  1,  0, -1, 8'h01, 8'h00, 8'h5A, 1, 0, 0, 0);
    add(0, 79,  0, -1, 8'h4F, 8'h00, 8'h5A, 1, 0, 0, 0);
    add(0, 80,  0, -1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 84,  0, -1, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
    add(0, 91,  0, -1, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
    add(0, 92,  0, -1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0,  5,  7, -1, 8'h05, 8'h07, 8'h5A, 1, 0, 0, 0);
    add(0,  0, 20,  2, 8'h00, 8'h14, 8'h5A, 1, 0, 0, 0);
    add(0, 79, 35, -1, 8'h4F, 8'h23, 8'h5A, 1, 0, 0, 0);
    add(0, 10, 37, -1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
    add(0, 10, 39, -1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    // frame 1 checkerboard, mode->1
    add(1,  0,  0, -1, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1);
    add(1, 31,  0, -1, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
    add(1, 32,  0, -1, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0);
    add(1, 90,  5, -1, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
    add(1,  0, 32, -1, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0);
    add(1, 32, 32,  1, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
    // frame 2 colour bars, mode->3
    add(2,  0,  0, -1, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 1);
    add(2,  9,  0, -1, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0);
    add(2, 10,  0, -1, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 0);
    add(2, 20,  3, -1, 8'h00, 8'hFF, 8'hFF, 1, 0, 0, 0);
    add(2, 30,  3, -1, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 0);
    add(2, 40,  3, -1, 8'hFF, 8'h00, 8'hFF, 1, 0, 0, 0);
    add(2, 50,  3, -1, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 0);
    add(2, 60,  3, -1, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 0);
    add(2, 69,  3, -1, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 0);
    add(2, 70,  3, -1, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
    add(2, 79,  3, -1, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
    add(2, 85,  3,  3, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
    // frame 3 grey ramp
    add(3,  0,  0, -1, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1);
    add(3, 33,  2, -1, 8'h21, 8'h21, 8'h21, 1, 0, 0, 0);
    add(3, 79, 10, -1, 8'h4F, 8'h4F, 8'h4F, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_out", {r, g, b, hs, vs, blank, sync, fs}, 64'h0);
    chk("rst_req", {req, rx, ry}, {1'b1, 13'h0});
    release_check("rel0");

    foreach (tv[i]) begin
      n = tv[i].f * FR + tv[i].y * HT + tv[i].x;
      wait_n(n);
      nm = $sformatf("pix_f%0d_%0d_%0d", tv[i].f, tv[i].x, tv[i].y);
      chk(nm, {r, g, b, blank, hs, vs, fs, sync},
          {tv[i].r, tv[i].g, tv[i].b, tv[i].bl, tv[i].hs, tv[i].vs, tv[i].fs, 1'b0});
      s  = n + LAT + 1;
      sx = s % HT;
      sy = (s / HT) % VT;
      a  = (sx < HD) && (sy < VD);
      chk({nm, "_req"}, {req, rx, ry}, {a, a ? 7'(sx) : 7'd0, a ? 6'(sy) : 6'd0});
      if (tv[i].set_mode >= 0) mode = 2'(tv[i].set_mode);
    end

    measure(0, hi, per); chk("hs_hi", hi, 8);    chk("hs_per", per, HT);
    measure(1, hi, per); chk("bl_hi", hi, HD);   chk("bl_per", per, HT);
    measure(2, hi, per); chk("vs_hi", hi, 2*HT); chk("vs_per", per, FR);
    measure(3, hi, per); chk("fs_hi", hi, 1);    chk("fs_per", per, FR);

    tog = 1'b1;
    measure(0, hi, per); chk("hs_hi_x2", hi, 16);     chk("hs_per_x2", per, 2*HT);
    measure(1, hi, per); chk("bl_hi_x2", hi, 2*HD);   chk("bl_per_x2", per, 2*HT);
    measure(2, hi, per); chk("vs_hi_x2", hi, 4*HT);   chk("vs_per_x2", per, 2*FR);
    measure(3, hi, per); chk("fs_hi_x2", hi, 2);      chk("fs_per_x2", per, 2*FR);
    tog = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_en0", stab_bad, 0);

    // Reset in the middle of a visible grey-ramp line.
    gd = 0;
    while (!(blank && r != 8'h00) && gd < 5000) begin @(negedge clk); gd++; end
    chk("mid_visible", {blank, (r != 8'h00)}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {r, g, b, hs, vs, blank, sync, fs}, 64'h0);
    chk("mid_rst_req", {req, rx, ry}, {1'b1, 13'h0});
    @(negedge clk);
    chk("mid_rst_hold", {r, g, b, hs, vs, blank, sync, fs}, 64'h0);
    release_check("rel1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_pipe.md
# vga_timing_pipe

Parametrised VGA timing generator and pixel pipeline for the DE2-class ADV7123 video DAC path. It drives the sync and blank signals, issues per-pixel read requests with coordinates to an upstream pixel source (frame buffer / renderer) with a configurable fetch latency, and aligns the returned colour with the sync signals. Built-in test patterns are selectable at frame boundaries. It sits between the rendering logic and the VGA pins, replacing the fixed 800x600 timing/colour-bar generator.

## Interface
- H_DISP, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BACK, 88, horizontal back porch (pixels)
- V_DISP, 600, active lines per frame
- V_FRONT, 1 / V_SYNC, 4 / V_BACK, 23, vertical porches and sync (lines)
- HS_ACTIVE, 1, level of vga_hs during sync; VS_ACTIVE, 1, same for vga_vs
- COLOR_W, 8, bits per colour channel
- LATENCY, 2, cycles from req to valid pix_rgb (≥1)
- clk  in  1  pixel-domain clock
- rst_n  in  1  reset: one clock; asynchronous, active-low
- en  in  1  pixel clock enable; all state holds when 0
- mode  in  2  0 external, 1 colour bars, 2 checkerboard, 3 grey ramp
- pix_rgb  in  3*COLOR_W  {r,g,b} from upstream, valid LATENCY enabled cycles after req
- req  out  1  pixel request (active-region pixel)
- req_x  out  clog2(H_DISP)  requested column
- req_y  out  clog2(V_DISP)  requested row
- vga_r / vga_g / vga_b  out  COLOR_W each  colour to DAC
- vga_hs / vga_vs  out  1  syncs
- vga_blank  out  1  active-low blank (1 = visible pixel)
- vga_sync  out  1  composite sync, tied 0
- frame_start  out  1  one enabled-cycle pulse aligned with output pixel (0,0)

## Operation
- Stage 0 counters: hcnt 0..H_TOTAL-1, vcnt 0..V_TOTAL-1, H_TOTAL = sum of H params, V_TOTAL likewise. Order within line: active [0,H_DISP), front porch, sync, back porch; vertical identical.
- hcnt wraps H_TOTAL-1 -> 0 and vcnt increments on the same cycle; vcnt wraps V_TOTAL-1 -> 0 on that same wrap cycle.
- Stage 0 decode: act = hcnt<H_DISP && vcnt<V_DISP; hs = HS_ACTIVE when hcnt in [H_DISP+H_FRONT, H_DISP+H_FRONT+H_SYNC), else ~HS_ACTIVE; vs same with vcnt.
- req = act (combinational from stage 0 registers); req_x = hcnt, req_y = vcnt when act, else 0.
- Active mode register mode_q loads mode only on the cycle hcnt and vcnt both wrap to 0; held otherwise.
- Patterns computed at stage 0 from (hcnt,vcnt):
  - 1: 8 vertical bars width H_DISP/8 (integer); last bar absorbs remainder; order white, yellow, cyan, green, magenta, red, blue, black; bar index tracked by a per-line sub-counter, no divider.
  - 2: white when hcnt[5]^vcnt[5], else black.
  - 3: all channels = hcnt[COLOR_W-1:0].
  - Channel full-scale = all ones, zero = all zeros.
- act, hs, vs, frame-start flag, mode_q select and pattern colour are delayed LATENCY enabled cycles to meet pix_rgb, then registered into outputs: colour = act_d ? (mode_d==0 ? pix_rgb : pattern_d) : 0.
- Non-active output pixels always drive colour 0 regardless of mode or pix_rgb.

## Timing
- Output (pins) lag stage 0 by LATENCY+1 enabled cycles; req lags nothing.
- All pipeline and counter registers advance only when en=1; with en=0 every output holds its value.
- Reset values: hcnt=vcnt=0, mode_q=0, all delay stages cleared, vga_r/g/b=0, vga_hs=~HS_ACTIVE, vga_vs=~VS_ACTIVE, vga_blank=0, vga_sync=0, frame_start=0, req reflects hcnt=vcnt=0 (1 after reset release).
- Reset mid-line/mid-frame: outputs go to reset values immediately (async), timing restarts at pixel (0,0); no partial-frame recovery.
- mode change mid-frame: no effect until next frame's first output pixel.
- pix_rgb sampled only at its aligned cycle; value outside active region ignored.

## Test plan
- Reset asserted mid-line -> all outputs at reset values within same cycle; after release, first vga_blank=1 exactly LATENCY+1 cycles later.
- Default params, en=1 -> line period 1056 cycles, vga_hs high 128 cycles starting 840 cycles after line start, vga_blank high 800; frame 628 lines, vga_vs high 4 lines; frame_start once per 663168 cycles.
- mode=1 -> output x 0..99 = FF/FF/FF, x 100..199 = FF/FF/00, x 700..799 = 00/00/00; blanking = 0.
- mode=0, LATENCY=2, bench returns pix_rgb = {req_x[7:0], req_y[7:0], 8'h5A} two cycles after req -> each output pixel carries its own x/y; no off-by-one at x=0 and x=799.
- mode switched 0->2 at line 300 -> rest of frame unchanged, next frame checkerboard (pixel (32,0) white, (0,0) black).
- en toggled 1/0 alternately -> all timings exactly double in clk cycles, outputs stable while en=0.
